// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA-CRT decryption engine: default operand
// width, cycles per modular multiplication and the controller state enums.
package rsa_pkg;

  localparam int WIDTH      = 6;
  localparam int MUL_CYCLES = WIDTH + 1;  // one load cycle plus WIDTH shift-add steps

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CHK,
    ST_RED_P,
    ST_EXP_P,
    ST_RED_Q,
    ST_EXP_Q,
    ST_CMB_MODP,
    ST_CMB_H,
    ST_CMB_HQ,
    ST_FIN,
    ST_DONE
  } state_t;

  // Which half of a square-and-multiply exponent bit is in flight.
  typedef enum logic {
    PH_SQR,
    PH_MUL
  } phase_t;

endpackage

// File: rtl/rsa_modmul.sv
// Iterative interleaved modular multiplier: acc = a*b mod m.
// b is consumed MSB first; each step doubles acc and conditionally adds a,
// with one conditional subtract of m after each partial result.
// Handshake: i_load starts an operation (1 cycle), then STEPS step cycles;
// o_done rises with the final step and holds until the next i_load.
// Precondition: a < m, which keeps every partial result below m.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = rsa_pkg::WIDTH,
  parameter int STEPS = MUL_CYCLES - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(STEPS + 1);

  logic [WIDTH-1:0] r_a, r_b, r_m, r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;

  logic [WIDTH:0]   w_m_ext, w_dbl, w_sum;
  logic [WIDTH-1:0] w_dbl_red, w_sum_red, w_next;

  // One shift-add step: double and reduce, then add a and reduce.
  assign w_m_ext   = {1'b0, r_m};
  assign w_dbl     = {r_acc, 1'b0};
  assign w_dbl_red = (w_dbl >= w_m_ext) ? WIDTH'(w_dbl - w_m_ext) : WIDTH'(w_dbl);
  assign w_sum     = {1'b0, w_dbl_red} + {1'b0, r_a};
  assign w_sum_red = (w_sum >= w_m_ext) ? WIDTH'(w_sum - w_m_ext) : WIDTH'(w_sum);
  assign w_next    = r_b[WIDTH-1] ? w_sum_red : w_dbl_red;

  // Operand capture on load, then one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_m    <= i_m;
      r_acc  <= '0;
      r_cnt  <= CW'(STEPS);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_acc <= w_next;
      r_b   <= r_b << 1;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_acc  = r_acc;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/rsa_crt_decrypt.sv
// RSA decryption via the Chinese Remainder Theorem: m = C^d mod N using
// (P, Q, Dp, Dq, Qinv). Every reduction, exponentiation step and
// recombination product runs on one shared rsa_modmul instance.
// Optional macro CONST_TIME_EN: execute the multiply on every exponent bit
// and discard it when the bit is 0, so latency does not depend on Dp/Dq.
module rsa_crt_decrypt
  import rsa_pkg::*;
#(
  parameter int WIDTH = rsa_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] Dp,
  input  logic [WIDTH-1:0] Dq,
  input  logic [WIDTH-1:0] Qinv,
  output logic [WIDTH-1:0] Result,
  output logic             Done,
  output logic             Err,
  output logic             Busy
);

  localparam int               BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  phase_t           r_phase;
  logic             r_armed, r_bad;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_c, r_p, r_q, r_n, r_dp, r_dq, r_qinv;
  logic [WIDTH-1:0] r_cp, r_r, r_m1, r_m2;

  logic             w_mul_load, w_mul_busy, w_mul_done, w_ready;
  logic [WIDTH-1:0] w_mul_a, w_mul_b, w_mul_m, w_mul_acc;
  logic             w_invalid, w_ebit, w_do_mul, w_exp_end;
  logic [WIDTH-1:0] w_exp_e, w_exp_m, w_r_after, w_d;
  logic [WIDTH:0]   w_d_sum;

  rsa_modmul #(
    .WIDTH(WIDTH),
    .STEPS(WIDTH)
  ) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_mul_load),
    .i_a   (w_mul_a),
    .i_b   (w_mul_b),
    .i_m   (w_mul_m),
    .o_acc (w_mul_acc),
    .o_busy(w_mul_busy),
    .o_done(w_mul_done)
  );

  assign w_ready   = w_mul_done & ~w_mul_busy;
  assign w_invalid = (r_p < WIDTH'(2)) || (r_q < WIDTH'(2)) || (r_n < WIDTH'(2)) || (r_qinv >= r_p);

  // Exponent walk: the Q half reuses the same sequencing as the P half.
  assign w_exp_e = (r_state == ST_EXP_Q) ? r_dq : r_dp;
  assign w_exp_m = (r_state == ST_EXP_Q) ? r_q : r_p;
  assign w_ebit  = w_exp_e[r_bit];
`ifdef CONST_TIME_EN
  assign w_do_mul = 1'b1;
`else
  assign w_do_mul = w_ebit;
`endif
  // A multiply issued for a zero exponent bit leaves r unchanged.
  assign w_r_after = (r_phase == PH_MUL && !w_ebit) ? r_r : w_mul_acc;
  assign w_exp_end = (r_bit == '0) && (r_phase == PH_MUL || !w_do_mul);

  // d = (m1 + P - t) mod P with t = m2 mod P arriving from the multiplier.
  assign w_d_sum = {1'b0, r_m1} + {1'b0, r_p} - {1'b0, w_mul_acc};
  assign w_d     = (w_d_sum >= {1'b0, r_p}) ? WIDTH'(w_d_sum - {1'b0, r_p}) : WIDTH'(w_d_sum);

  // Select the next multiplier job in the cycle the previous one completes.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    w_mul_load = 1'b0;
    w_mul_a    = '0;
    w_mul_b    = '0;
    w_mul_m    = '0;
    case (r_state)
      ST_CHK: if (!w_invalid) begin
        w_mul_load = 1'b1; w_mul_a = ONE; w_mul_b = r_c; w_mul_m = r_p;
      end
      ST_RED_P: if (w_ready) begin
        w_mul_load = 1'b1; w_mul_a = ONE; w_mul_b = ONE; w_mul_m = r_p;
      end
      ST_RED_Q: if (w_ready) begin
        w_mul_load = 1'b1; w_mul_a = ONE; w_mul_b = ONE; w_mul_m = r_q;
      end
      ST_EXP_P, ST_EXP_Q: if (w_ready) begin
        w_mul_load = 1'b1;
        if (!w_exp_end) begin
          if (r_phase == PH_SQR && w_do_mul) begin
            w_mul_a = w_mul_acc; w_mul_b = r_cp; w_mul_m = w_exp_m;
          end else begin
            w_mul_a = w_r_after; w_mul_b = w_r_after; w_mul_m = w_exp_m;
          end
        end else if (r_state == ST_EXP_P) begin
          w_mul_a = ONE; w_mul_b = r_c; w_mul_m = r_q;
        end else begin
          w_mul_a = ONE; w_mul_b = w_r_after; w_mul_m = r_p;
        end
      end
      ST_CMB_MODP: if (w_ready) begin
        w_mul_load = 1'b1; w_mul_a = r_qinv; w_mul_b = w_d; w_mul_m = r_p;
      end
      ST_CMB_H: if (w_ready) begin
        w_mul_load = 1'b1; w_mul_a = w_mul_acc; w_mul_b = r_q; w_mul_m = r_n;
      end
      default: ;
    endcase
  end

  // Controller: handshake, operand capture, result bookkeeping, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= PH_SQR;
      r_armed <= 1'b1;
      r_bad   <= 1'b0;
      r_bit   <= '0;
      r_c     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_n     <= '0;
      r_dp    <= '0;
      r_dq    <= '0;
      r_qinv  <= '0;
      r_cp    <= '0;
      r_r     <= '0;
      r_m1    <= '0;
      r_m2    <= '0;
      Result  <= '0;
      Done    <= 1'b0;
      Err     <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      if (!Start) r_armed <= 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE: if (Start && r_armed) begin
          r_armed <= 1'b0;
          r_c     <= C;
          r_p     <= P;
          r_q     <= Q;
          r_n     <= N;
          r_dp    <= Dp;
          r_dq    <= Dq;
          r_qinv  <= Qinv;
          Result  <= '0;
          Done    <= 1'b0;
          Err     <= 1'b0;
          Busy    <= 1'b1;
          r_state <= ST_CHK;
        end
        ST_CHK: begin
          r_bad   <= w_invalid;
          r_state <= w_invalid ? ST_FIN : ST_RED_P;
        end
        ST_RED_P, ST_RED_Q: if (w_ready) begin
          r_cp    <= w_mul_acc;
          r_r     <= ONE;
          r_bit   <= BW'(WIDTH - 1);
          r_phase <= PH_SQR;
          r_state <= (r_state == ST_RED_P) ? ST_EXP_P : ST_EXP_Q;
        end
        ST_EXP_P, ST_EXP_Q: if (w_ready) begin
          r_r <= w_r_after;
          if (w_exp_end) begin
            if (r_state == ST_EXP_P) begin
              r_m1    <= w_r_after;
              r_state <= ST_RED_Q;
            end else begin
              r_m2    <= w_r_after;
              r_state <= ST_CMB_MODP;
            end
          end else if (r_phase == PH_SQR && w_do_mul) begin
            r_phase <= PH_MUL;
          end else begin
            r_phase <= PH_SQR;
            r_bit   <= r_bit - BW'(1);
          end
        end
        ST_CMB_MODP: if (w_ready) r_state <= ST_CMB_H;
        ST_CMB_H:    if (w_ready) r_state <= ST_CMB_HQ;
        ST_CMB_HQ: if (w_ready) begin
          r_r     <= w_mul_acc;
          r_state <= ST_FIN;
        end
        ST_FIN: begin
          Result  <= r_bad ? '0 : r_m2 + r_r;
          Err     <= r_bad;
          Done    <= 1'b1;
          Busy    <= 1'b0;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rsa_crt_decrypt.md
# rsa_crt_decrypt

RSA decryption engine using the Chinese Remainder Theorem (CRT): it takes ciphertext C and the private key in CRT form, and recovers the plaintext m = C^d mod N. It is the decrypt-side counterpart of the existing `RSA` modular-exponentiation core, which encrypts with (Data, N, Key). It uses the same Start/Done handshake and the same WIDTH-bit datapath, so a test harness can encrypt with `RSA` and decrypt with this block. All exponentiation and reduction steps run on one shared iterative modular multiplier.

## Interface
- WIDTH, 6, bit width of every operand and of Result
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  request; level-sampled and re-armed only after it has been seen low
- C  in  WIDTH  ciphertext
- P, Q  in  WIDTH each  prime factors, N = P*Q
- N  in  WIDTH  modulus
- Dp, Dq  in  WIDTH each  d mod (P-1), d mod (Q-1)
- Qinv  in  WIDTH  Q^-1 mod P
- Result  out  WIDTH  plaintext; valid while Done=1
- Done  out  1  completion; held high until the next accepted Start
- Err  out  1  operand error; valid while Done=1
- Busy  out  1  high from acceptance until Done rises

## Operation
- Reset value of every output is 0. Reset sets state IDLE and armed=1.
- `armed` is cleared when a request is accepted and set on any cycle where Start=0.
- **Acceptance:** a request is accepted in IDLE or DONE when Start=1 and armed=1. On acceptance:
  - all inputs are registered;
  - Done, Err and Result are cleared;
  - Busy is set.
- **Ignored requests:** Start while Busy=1 is ignored. A Start held high across completion does not retrigger.
- **Operand check** (the cycle after acceptance):
  - The request is invalid if P<2, Q<2, N<2 or Qinv>=P.
  - On an invalid request, go to DONE with Err=1 and Result=0.
- **States:** IDLE → CHK → RED_P → EXP_P → RED_Q → EXP_Q → CMB_MODP → CMB_H → CMB_HQ → FIN → DONE.
- **Modmul(a,b,m):** interleaved shift-add, MSB of b first.
  - Per step: acc = 2·acc mod m, then acc = acc + a mod m if the b bit is 1.
  - Each step uses a WIDTH+1-bit intermediate and one conditional subtract per partial result.
  - Precondition: a < m. b may be any value.
- **Sequence:**
  - RED_P: cp = modmul(1, C, P).
  - EXP_P: m1 = cp^Dp mod P, left-to-right over all WIDTH bits of Dp, starting from r=1. Per bit: square r, then multiply by cp if the bit is 1.
  - RED_Q and EXP_Q: the same steps with Q and Dq, giving m2.
  - CMB_MODP: t = modmul(1, m2, P).
  - CMB_H: d = (m1 + P − t) mod P, then h = modmul(Qinv, d, P).
  - CMB_HQ: hq = modmul(h, Q, N).
  - FIN: Result = m2 + hq, truncated to WIDTH bits. N ≠ P*Q is not detected.
- In DONE, Busy=0 and Done=1. Result and Err hold their values.

## Timing
- One modmul takes WIDTH+1 cycles: 1 load plus WIDTH steps.
- Latency is counted from the acceptance edge to the edge where Done rises:
  - L = K·(WIDTH+1) + 2, where K is the number of modmuls.
  - K = 4·WIDTH + 5 with CONST_TIME_EN.
  - For WIDTH=6, L = 205 cycles.
- Error path: Done rises 2 cycles after acceptance.
- Reset mid-operation immediately returns the block to IDLE. All outputs go to 0, and the partial state is discarded.

## Configuration
- CONST_TIME_EN defined:
  - the multiply step executes on every exponent bit;
  - its result is discarded when the bit is 0;
  - latency is independent of Dp and Dq.
- CONST_TIME_EN undefined:
  - the multiply is skipped when the exponent bit is 0;
  - K = 2·WIDTH + popcount(Dp) + popcount(Dq) + 5;
  - Result is identical.

## Structure
- Package rsa_pkg holds:
  - the WIDTH default;
  - the state enum;
  - the MUL_CYCLES = WIDTH+1 constant.
- Sub-module rsa_modmul: load/busy/done handshake, operands a, b, m, result acc. It is instantiated once and reused by every step.

## Test plan
All scenarios use WIDTH=6 with P=5, Q=11, N=55, Dp=3, Dq=7, Qinv=1 unless stated otherwise.
- **Basic decrypt:** C=14 → Result=9, Err=0, Done after 205 cycles.
- **Nonzero CRT term:** C=50 → Result=30. Internal checks: m1=0, m2=8, h=2.
- **Edge values:** C=0 → 0; C=1 → 1.
- **Operand error:** P=1 → Err=1, Result=0, Done 2 cycles after acceptance. Qinv=5 gives the same response.
- **Handshake:**
  - Start held high for 3 cycles → exactly one run.
  - Start pulsed mid-run → ignored.
  - Start dropped and reasserted after Done → new run, with Done low from acceptance.
- **Reset and configuration:**
  - rst_n low at cycle 100 of a run → all outputs 0, block in IDLE.
  - Without CONST_TIME_EN, C=14 → Result=9 after 156 cycles.
